// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: single-cycle ops, iterative shift-add MUL, restoring DIV/MOD.
// Define SEQ_ALU_FAST_MUL_EN to make MUL combinational and drop the MUL state.
//
// state | meaning
// IDLE  | waiting for start_i
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
// DONE  | done_o pulse, results valid
module seq_alu #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int IMM_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [4:0]       aluOp_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             flag_o,
    output logic             divz_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [4:0] OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_MUL  = 5'd3;
    localparam logic [4:0] OP_DIV  = 5'd4,  OP_MOD  = 5'd5,  OP_AND  = 5'd6,  OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8,  OP_NOT  = 5'd9,  OP_SLL  = 5'd10, OP_SRL  = 5'd11;
    localparam logic [4:0] OP_SAR  = 5'd12, OP_SAL  = 5'd13, OP_LOD  = 5'd14, OP_STO  = 5'd15;
    localparam logic [4:0] OP_LODI = 5'd16, OP_STOI = 5'd17, OP_MOV  = 5'd18, OP_MOVI = 5'd19;
    localparam logic [4:0] OP_JMP  = 5'd20, OP_JMPI = 5'd21, OP_JEQ  = 5'd22, OP_JNE  = 5'd23;
    localparam logic [4:0] OP_JG   = 5'd24, OP_JL   = 5'd25, OP_JGU  = 5'd26, OP_JLU  = 5'd27;

`ifdef SEQ_ALU_FAST_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem_q, quo_q, divisor_q;
    logic               mod_q;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   imm_short, imm_long;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_flag;
    logic               is_div, is_iter_mul;

    assign shamt     = imm_i[SHAMT_W-1:0];
    assign imm_short = WIDTH'($signed(imm_i[4:0]));
    assign imm_long  = WIDTH'($signed(imm_i));
    assign is_div    = (aluOp_i == OP_DIV) || (aluOp_i == OP_MOD);
`ifdef SEQ_ALU_FAST_MUL_EN
    assign is_iter_mul = 1'b0;
`else
    assign is_iter_mul = (aluOp_i == OP_MUL);
`endif

    // DIV/MOD only reach this path with a zero divisor; otherwise they go iterative.
    always_comb begin
        sc_result = '0;
        sc_flag   = 1'b0;
        case (aluOp_i)
            OP_ADD:           sc_result = data1_i + data2_i;
            OP_SUB:           sc_result = data1_i - data2_i;
            OP_MUL:           sc_result = data1_i * data2_i;
            OP_DIV:           sc_result = '1;
            OP_MOD:           sc_result = data1_i;
            OP_AND:           sc_result = data1_i & data2_i;
            OP_OR:            sc_result = data1_i | data2_i;
            OP_XOR:           sc_result = data1_i ^ data2_i;
            OP_NOT:           sc_result = ~data1_i;
            OP_SLL, OP_SAL:   sc_result = data1_i << shamt;
            OP_SRL:           sc_result = data1_i >> shamt;
            OP_SAR:           sc_result = WIDTH'($signed(data1_i) >>> shamt);
            OP_LOD, OP_STO,
            OP_MOV:           sc_result = data2_i;
            OP_LODI, OP_STOI: sc_result = data2_i + imm_short;
            OP_MOVI:          sc_result = imm_long;
            OP_JEQ:           sc_flag   = (data1_i == data2_i);
            OP_JNE:           sc_flag   = (data1_i != data2_i);
            OP_JG:            sc_flag   = ($signed(data1_i) > $signed(data2_i));
            OP_JL:            sc_flag   = ($signed(data1_i) < $signed(data2_i));
            OP_JGU:           sc_flag   = (data1_i > data2_i);
            OP_JLU:           sc_flag   = (data1_i < data2_i);
            default:          sc_result = '0;
        endcase
    end

    // Restoring step: remainder < divisor always holds, so bit WIDTH of the trial is its sign.
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] rem_n, quo_n;
    always_comb begin
        div_trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor_q};
        if (!div_trial[WIDTH]) begin
            rem_n = div_trial[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_n = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

`ifndef SEQ_ALU_FAST_MUL_EN
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, acc_n;
    assign acc_n = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            mod_q     <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            result_o  <= '0;
            flag_o    <= 1'b0;
            divz_o    <= 1'b0;
`ifndef SEQ_ALU_FAST_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        if (is_iter_mul) begin
`ifndef SEQ_ALU_FAST_MUL_EN
                            state    <= S_MUL;
                            busy_o   <= 1'b1;
                            cnt      <= CNT_W'(WIDTH);
                            acc_q    <= '0;
                            mcand_q  <= data1_i;
                            mplier_q <= data2_i;
`endif
                        end else if (is_div && (data2_i != '0)) begin
                            state     <= S_DIV;
                            busy_o    <= 1'b1;
                            cnt       <= CNT_W'(WIDTH);
                            rem_q     <= '0;
                            quo_q     <= data1_i;
                            divisor_q <= data2_i;
                            mod_q     <= (aluOp_i == OP_MOD);
                        end else begin
                            state    <= S_DONE;
                            done_o   <= 1'b1;
                            result_o <= sc_result;
                            flag_o   <= sc_flag;
                            divz_o   <= is_div;
                        end
                    end
                end
`ifndef SEQ_ALU_FAST_MUL_EN
                S_MUL: begin
                    acc_q    <= acc_n;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt      <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state    <= S_DONE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        result_o <= acc_n;
                        flag_o   <= 1'b0;
                        divz_o   <= 1'b0;
                    end
                end
`endif
                S_DIV: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state    <= S_DONE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        result_o <= mod_q ? rem_n : quo_n;
                        flag_o   <= 1'b0;
                        divz_o   <= 1'b0;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
